// File: rtl/up_counter.sv
// Seeded up-counter: captures a seed S and step count N, then adds one per
// cycle N times and presents (S + N) mod 2^M_WIDTH with a held done flag.
module up_counter #(
  parameter int M_WIDTH     = 3,
  parameter int INPUT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] in,
  input  logic                   start,
  input  logic [M_WIDTH-1:0]     lfsr_out,
  output logic [M_WIDTH-1:0]     random_out,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [M_WIDTH-1:0]     r_acc;
  logic [INPUT_WIDTH-1:0] r_remaining;
  logic [M_WIDTH-1:0]     r_result;
  logic                   r_done;

  state_t                 w_stateNext;
  logic [M_WIDTH-1:0]     w_accNext;
  logic [INPUT_WIDTH-1:0] w_remainingNext;
  logic [M_WIDTH-1:0]     w_resultNext;
  logic                   w_doneNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_result    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_acc       <= w_accNext;
      r_remaining <= w_remainingNext;
      r_result    <= w_resultNext;
      r_done      <= w_doneNext;
    end
  end

  // Dropping start mid-count abandons the run before any completion check.
  always_comb begin
    w_stateNext     = r_state;
    w_accNext       = r_acc;
    w_remainingNext = r_remaining;
    w_resultNext    = r_result;
    w_doneNext      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accNext       = lfsr_out;
          w_remainingNext = in;
          w_stateNext     = COUNT;
        end
      end
      COUNT: begin
        if (!start) begin
          w_stateNext = IDLE;
        end else if (r_remaining != '0) begin
          w_accNext       = r_acc + 1'b1;
          w_remainingNext = r_remaining - 1'b1;
        end else begin
          w_resultNext = r_acc;
          w_doneNext   = 1'b1;
          w_stateNext  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_doneNext = 1'b1;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign random_out = r_result;
  assign done       = r_done;

endmodule

// File: tb/tb_up_counter.sv
// Scoreboard bench for up_counter: expected result and latency are queued at
// launch and popped once done rises.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in;
  logic       start;
  logic [2:0] lfsr_out;
  logic [2:0] random_out;
  logic       done;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  up_counter #(.M_WIDTH(3), .INPUT_WIDTH(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .start      (start),
    .lfsr_out   (lfsr_out),
    .random_out (random_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  // Drives a capture edge, optionally queues the expectation, then scrambles inputs.
  task automatic applyStimulus(input logic [2:0] s, input logic [9:0] n, input bit push);
    exp_t       e;
    logic [2:0] sum;
    start    = 1'b1;
    lfsr_out = s;
    in       = n;
    sum      = s + n[2:0];
    e.res    = sum;
    e.lat    = int'(n) + 1;
    if (push) expQ.push_back(e);
    waitEdge();
    lfsr_out = 3'($urandom);
    in       = 10'($urandom);
  endtask

  task automatic waitForDone(input int bound, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < bound) begin
      waitEdge();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in = 10'd3; lfsr_out = 3'd5;
    waitEdge();
    waitEdge();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (random_out !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_result: got %0d expected 0", random_out);
    end
    start = 1'b0;
    rst   = 1'b0;
    waitEdge();
  endtask

  task automatic test_basic();
    exp_t e;
    int   edges;
    applyStimulus(3'b101, 10'd5, 1'b1);
    e = expQ.pop_front();
    waitForDone(e.lat + 20, edges);
    checks++;
    if (edges !== e.lat) begin
      errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", edges, e.lat);
    end
    checks++;
    if (random_out !== e.res) begin
      errors++; $display("[TB] FAIL basic_result: got %0d expected %0d", random_out, e.res);
    end
    for (int i = 0; i < 3; i++) begin
      waitEdge();
      checks++;
      if (done !== 1'b1 || random_out !== 3'b010) begin
        errors++; $display("[TB] FAIL done_hold: done %b result %0d expected 1 / 2", done, random_out);
      end
    end
    start = 1'b0;
    waitEdge();
    checks++;
    if (done !== 1'b0 || random_out !== 3'b010) begin
      errors++; $display("[TB] FAIL done_release: done %b result %0d expected 0 / 2", done, random_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   edges;
    applyStimulus(3'b000, 10'd2, 1'b1);
    e = expQ.pop_front();
    waitForDone(e.lat + 20, edges);
    checks++;
    if (edges !== e.lat) begin
      errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", edges, e.lat);
    end
    checks++;
    if (random_out !== e.res) begin
      errors++; $display("[TB] FAIL b2b_result: got %0d expected %0d", random_out, e.res);
    end
    start = 1'b0;
    waitEdge();
  endtask

  task automatic test_zero();
    exp_t e;
    int   edges;
    applyStimulus(3'b011, 10'd0, 1'b1);
    e = expQ.pop_front();
    waitForDone(e.lat + 20, edges);
    checks++;
    if (edges !== 1) begin
      errors++; $display("[TB] FAIL zero_latency: got %0d expected 1", edges);
    end
    checks++;
    if (random_out !== 3'b011) begin
      errors++; $display("[TB] FAIL zero_result: got %0d expected 3", random_out);
    end
    start = 1'b0;
    waitEdge();
  endtask

  task automatic test_wrap();
    exp_t e;
    int   edges;
    applyStimulus(3'b111, 10'd1023, 1'b1);
    e = expQ.pop_front();
    waitForDone(e.lat + 20, edges);
    checks++;
    if (edges !== 1024) begin
      errors++; $display("[TB] FAIL wrap_latency: got %0d expected 1024", edges);
    end
    checks++;
    if (random_out !== 3'b110) begin
      errors++; $display("[TB] FAIL wrap_result: got %0d expected 6", random_out);
    end
    start = 1'b0;
    waitEdge();
  endtask

  task automatic test_abort();
    exp_t e;
    int   edges;
    applyStimulus(3'b001, 10'd5, 1'b0);
    waitEdge();
    waitEdge();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      waitEdge();
      checks++;
      if (done !== 1'b0 || random_out !== 3'b110) begin
        errors++; $display("[TB] FAIL abort_hold: done %b result %0d expected 0 / 6", done, random_out);
      end
    end
    applyStimulus(3'b010, 10'd1, 1'b1);
    e = expQ.pop_front();
    waitForDone(e.lat + 20, edges);
    checks++;
    if (edges !== e.lat || random_out !== e.res) begin
      errors++; $display("[TB] FAIL abort_restart: edges %0d result %0d expected %0d / %0d", edges, random_out, e.lat, e.res);
    end
    start = 1'b0;
    waitEdge();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   edges;
    applyStimulus(3'b100, 10'd6, 1'b0);
    waitEdge();
    waitEdge();
    rst = 1'b1;
    waitEdge();
    checks++;
    if (done !== 1'b0 || random_out !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_mid: done %b result %0d expected 0 / 0", done, random_out);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitEdge();
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_idle: done %b expected 0", done);
      end
    end
    applyStimulus(3'b001, 10'd1, 1'b1);
    e = expQ.pop_front();
    waitForDone(e.lat + 20, edges);
    checks++;
    if (edges !== e.lat || random_out !== e.res) begin
      errors++; $display("[TB] FAIL reset_restart: edges %0d result %0d expected %0d / %0d", edges, random_out, e.lat, e.res);
    end
    start = 1'b0;
    waitEdge();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in = '0; lfsr_out = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_wrap();
    test_abort();
    test_reset_mid();
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
